dtmf_digit_fifo: RTL and testbench



---
 rtl/dtmf_digit_fifo_if.sv | 41 ++++
 rtl/dtmf_digit_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_dtmf_digit_fifo.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dtmf_digit_fifo_if.sv
// -----------------------------------------------------------------------------
// dtmf_digit_fifo_if
// Groups the digit-register input pair and the host-side pop/status signals
// of the DTMF digit FIFO into one bundle.
//
// Signals:
//   digit_in   [7:0]          digit code from the digit register
//   flag_in                   digit-valid level (asynchronous to clk)
//   pop                       consumer removes the head entry
//   clear_ovf                 clears the sticky overflow flag
//   dout       [7:0]          head entry (show-ahead)
//   dout_valid                FIFO not empty
//   count      [log2(DEPTH):0] occupancy, 0..DEPTH
//   overflow                  sticky: a digit was dropped while full
//
// Modports:
//   master - the digit source / host side
//   slave  - the FIFO itself
// -----------------------------------------------------------------------------
interface dtmf_digit_fifo_if #(
    parameter int DEPTH = 8
);
    logic [7:0]              digit_in;
    logic                    flag_in;
    logic                    pop;
    logic                    clear_ovf;
    logic [7:0]              dout;
    logic                    dout_valid;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;

    modport master (
        output digit_in, flag_in, pop, clear_ovf,
        input  dout, dout_valid, count, overflow
    );

    modport slave (
        input  digit_in, flag_in, pop, clear_ovf,
        output dout, dout_valid, count, overflow
    );
endinterface

// File: rtl/dtmf_digit_fifo.sv
// -----------------------------------------------------------------------------
// dtmf_digit_fifo
// Takes the DTMF receiver's detected digit/flag pair, resynchronises it into
// the clk domain, captures each digit exactly once per flag assertion and
// buffers it in a small show-ahead FIFO for the host to pop.
//
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low; clears all state
//   bus    - dtmf_digit_fifo_if.slave (digit_in, flag_in, pop, clear_ovf in;
//            dout, dout_valid, count, overflow out)
//
// Parameters:
//   DEPTH           - FIFO entries, power of two, 2..16
//   DEBOUNCE_CYCLES - stable cycles required before capture, 1..15
//                     (exists only when DTMF_DEBOUNCE_EN is defined)
//
// Configuration macro:
//   DTMF_DEBOUNCE_EN - defined: digit must be stable for DEBOUNCE_CYCLES
//                      cycles in QUAL before it is pushed.
//                      undefined: digit is pushed on the first cycle the
//                      synchronised flag is seen high.
// -----------------------------------------------------------------------------
module dtmf_digit_fifo #(
    parameter int DEPTH = 8
`ifdef DTMF_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    dtmf_digit_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

    logic [1:0]    r_flagSync;
    logic [7:0]    r_digitSync1;
    logic [7:0]    r_digitSync2;
    logic          w_flagS;
    logic [7:0]    w_digitS;

    state_t        r_state;
    logic          w_push;
    logic [7:0]    w_pushData;

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_dout;
    logic          r_overflow;

    logic          w_doPop;
    logic          w_doPush;
    logic          w_drop;
    logic [PW-1:0] w_nextRdPtr;
    logic [CW-1:0] w_nextCount;

    // Two-flop synchroniser; the digit follows the same two-stage path so it
    // lines up with the flag (digit_in is stable while flag_in is high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flagSync   <= '0;
            r_digitSync1 <= '0;
            r_digitSync2 <= '0;
        end else begin
            r_flagSync   <= {r_flagSync[0], bus.flag_in};
            r_digitSync1 <= bus.digit_in;
            r_digitSync2 <= r_digitSync1;
        end
    end

    assign w_flagS  = r_flagSync[1];
    assign w_digitS = r_digitSync2;

`ifdef DTMF_DEBOUNCE_EN
    logic [3:0] r_qualCnt;
    logic [7:0] r_candidate;

    // The push is decoded from the current state so it lands on the same edge
    // as the counter reaching its target, not one cycle later.
    always_comb begin
        w_push     = 1'b0;
        w_pushData = r_candidate;
        if (r_state == QUAL && w_flagS && w_digitS == r_candidate &&
            (r_qualCnt + 4'd1) == 4'(DEBOUNCE_CYCLES)) begin
            w_push = 1'b1;
        end
    end

    // Capture FSM: a digit change during qualification restarts the count
    // with the new digit as candidate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_qualCnt   <= '0;
            r_candidate <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_flagS) begin
                        r_state     <= QUAL;
                        r_qualCnt   <= '0;
                        r_candidate <= w_digitS;
                    end
                end
                QUAL: begin
                    if (!w_flagS) begin
                        r_state <= IDLE;
                    end else if (w_digitS != r_candidate) begin
                        r_candidate <= w_digitS;
                        r_qualCnt   <= '0;
                    end else begin
                        r_qualCnt <= r_qualCnt + 4'd1;
                        if (w_push) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!w_flagS) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    // Without debounce the first synchronised flag cycle pushes directly.
    always_comb begin
        w_push     = (r_state == IDLE) && w_flagS;
        w_pushData = w_digitS;
    end

    // Capture FSM: QUAL is skipped; HOLD blocks further pushes until the
    // flag drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_flagS) begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!w_flagS) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`endif

    // A pop on empty is ignored; a push on full is accepted only when a pop
    // frees the slot in the same cycle.
    assign w_doPop     = bus.pop && (r_count != '0);
    assign w_doPush    = w_push && ((r_count != FULL_COUNT) || w_doPop);
    assign w_drop      = w_push && (r_count == FULL_COUNT) && !w_doPop;
    assign w_nextRdPtr = r_rdPtr + PW'(w_doPop);
    assign w_nextCount = r_count + CW'(w_doPush) - CW'(w_doPop);

    // FIFO storage and pointers. dout is registered from the next head; when
    // the next head is the slot being written this cycle, the incoming digit
    // is forwarded. dout holds its value once the FIFO drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_dout     <= '0;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= w_pushData;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            r_rdPtr <= w_nextRdPtr;
            r_count <= w_nextCount;
            if (w_nextCount != '0) begin
                if (w_doPush && (r_wrPtr == w_nextRdPtr)) begin
                    r_dout <= w_pushData;
                end else begin
                    r_dout <= r_mem[w_nextRdPtr];
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = (r_count != '0);
    assign bus.count      = r_count;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_dtmf_digit_fifo.sv
// -----------------------------------------------------------------------------
// tb_dtmf_digit_fifo
// Directed bench for dtmf_digit_fifo (DEPTH = 8). Expected digits are queued
// when the stimulus is issued; a monitor pops the queue and compares dout on
// every accepted pop. Status outputs are compared directly in the main flow.
// Honours DTMF_DEBOUNCE_EN for the expected capture latency and behaviour.
// -----------------------------------------------------------------------------
module tb_dtmf_digit_fifo;
    localparam int DEPTH = 8;
`ifdef DTMF_DEBOUNCE_EN
    localparam int LAT_EDGE = 6;
`else
    localparam int LAT_EDGE = 2;
`endif

    logic clk;
    logic resetN;
    int   checks;
    int   errors;
    logic [7:0] sbQueue [$];

    dtmf_digit_fifo_if #(.DEPTH(DEPTH)) bus ();

    dtmf_digit_fifo #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (resetN),
        .bus   (bus.slave)
    );

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the run wanders off
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one clock, leaving inputs to change away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One flag assertion with a fixed digit, followed by a low period
    task automatic applyStimulus(input logic [7:0] digit, input int highCycles);
        bus.digit_in = digit;
        bus.flag_in  = 1'b1;
        repeat (highCycles) tick();
        bus.flag_in  = 1'b0;
        repeat (5) tick();
    endtask

    task automatic popOne();
        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
    endtask

    task automatic popAll();
        int guard;
        guard = 0;
        while (bus.dout_valid && guard < DEPTH + 2) begin
            popOne();
            guard++;
        end
        checkOutput("drain_count", 32'(bus.count), 32'd0);
    endtask

    // Scoreboard monitor: every accepted pop must present the oldest expected digit
    always @(negedge clk) begin
        if (resetN && bus.pop && bus.dout_valid) begin
            if (sbQueue.size() == 0) begin
                checkOutput("sb_unexpected_entry", 32'(bus.dout), 32'hFFFF_FFFF);
            end else begin
                checkOutput("dout", 32'(bus.dout), 32'(sbQueue.pop_front()));
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        resetN        = 1'b0;
        bus.digit_in  = 8'h00;
        bus.flag_in   = 1'b0;
        bus.pop       = 1'b0;
        bus.clear_ovf = 1'b0;
        repeat (3) tick();

        // Reset values
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        checkOutput("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
        checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("rst_dout", 32'(bus.dout), 32'h00);
        resetN = 1'b1;
        repeat (2) tick();

        // Single digit held 20 cycles: one entry, latency checked
        bus.digit_in = 8'h35;
        bus.flag_in  = 1'b1;
        for (int e = 0; e <= LAT_EDGE; e++) begin
            tick();
            if (e == LAT_EDGE - 1) checkOutput("lat_before", 32'(bus.dout_valid), 32'd0);
            if (e == LAT_EDGE)     checkOutput("lat_at", 32'(bus.dout_valid), 32'd1);
        end
        sbQueue.push_back(8'h35);
        repeat (19 - LAT_EDGE) tick();
        bus.flag_in = 1'b0;
        repeat (5) tick();
        checkOutput("single_count", 32'(bus.count), 32'd1);
        checkOutput("single_dout", 32'(bus.dout), 32'h35);
        popAll();

        // Digit change under one flag
        bus.digit_in = 8'h31;
        bus.flag_in  = 1'b1;
        repeat (2) tick();
        bus.digit_in = 8'h32;
        repeat (10) tick();
        bus.flag_in = 1'b0;
        repeat (5) tick();
`ifdef DTMF_DEBOUNCE_EN
        sbQueue.push_back(8'h32);
`else
        sbQueue.push_back(8'h31);
`endif
        checkOutput("change_count", 32'(bus.count), 32'd1);
        popAll();

        // Short flag: filtered with debounce, captured without
        applyStimulus(8'h33, 3);
`ifdef DTMF_DEBOUNCE_EN
        checkOutput("glitch_count", 32'(bus.count), 32'd0);
`else
        checkOutput("glitch_count", 32'(bus.count), 32'd1);
        sbQueue.push_back(8'h33);
        popAll();
`endif

        // Fill plus one: ninth digit dropped, overflow sticky until cleared
        for (int d = 0; d < 9; d++) begin
            applyStimulus(8'h30 + 8'(d), 8);
            if (d < DEPTH) sbQueue.push_back(8'h30 + 8'(d));
        end
        checkOutput("fill_count", 32'(bus.count), 32'd8);
        checkOutput("fill_overflow", 32'(bus.overflow), 32'd1);
        popAll();
        checkOutput("ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        checkOutput("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Full with pop on the push edge: accepted, no overflow
        for (int d = 0; d < DEPTH; d++) begin
            applyStimulus(8'h40 + 8'(d), 8);
            sbQueue.push_back(8'h40 + 8'(d));
        end
        bus.digit_in = 8'h48;
        bus.flag_in  = 1'b1;
        repeat (LAT_EDGE) tick();
        sbQueue.push_back(8'h48);
        popOne();
        checkOutput("fullpop_count", 32'(bus.count), 32'd8);
        checkOutput("fullpop_overflow", 32'(bus.overflow), 32'd0);
        repeat (6) tick();
        bus.flag_in = 1'b0;
        repeat (5) tick();
        checkOutput("fullpop_hold_count", 32'(bus.count), 32'd8);
        popAll();

        // Pop on empty is ignored
        popOne();
        checkOutput("empty_pop_count", 32'(bus.count), 32'd0);

        // Push and pop together on empty: push wins
        bus.digit_in = 8'h51;
        bus.flag_in  = 1'b1;
        repeat (LAT_EDGE) tick();
        popOne();
        checkOutput("emptypush_count", 32'(bus.count), 32'd1);
        sbQueue.push_back(8'h51);
        bus.flag_in = 1'b0;
        repeat (5) tick();
        popAll();

        // Reset mid-capture with entries stored, release with flag still high
        applyStimulus(8'h61, 8);
        applyStimulus(8'h62, 8);
        applyStimulus(8'h63, 8);
        checkOutput("pre_reset_count", 32'(bus.count), 32'd3);
        bus.digit_in = 8'h64;
        bus.flag_in  = 1'b1;
        repeat (3) tick();
        resetN = 1'b0;
        #1;
        checkOutput("async_rst_count", 32'(bus.count), 32'd0);
        checkOutput("async_rst_valid", 32'(bus.dout_valid), 32'd0);
        checkOutput("async_rst_overflow", 32'(bus.overflow), 32'd0);
        sbQueue.delete();
        repeat (2) tick();
        resetN = 1'b1;
        sbQueue.push_back(8'h64);
        repeat (12) tick();
        checkOutput("post_rst_count", 32'(bus.count), 32'd1);
        bus.flag_in = 1'b0;
        repeat (5) tick();
        checkOutput("post_rst_hold_count", 32'(bus.count), 32'd1);
        popAll();

        checkOutput("sb_leftover", 32'(sbQueue.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
